// File: rtl/instr_prefetch.sv
// Instruction prefetch: fetches sequential words into a DEPTH-entry FIFO and flushes on redirect.
// Acked data is visible the next cycle; a fetch is only issued when a FIFO slot is reserved for it.
module instr_prefetch #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                       clk,
  input  logic                       n_rst,
  output logic                       imem_req,
  output logic [31:0]                imem_addr,
  input  logic                       imem_ack,
  input  logic [31:0]                imem_rdata,
  input  logic                       redirect,
  input  logic [31:0]                redirect_pc,
  output logic                       instr_valid,
  output logic [31:0]                instr,
  output logic [31:0]                instr_pc,
  input  logic                       instr_ready,
  output logic [$clog2(DEPTH):0]     fifo_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DROP} state_t;

  state_t          state_q, state_d;
  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic [31:0]     drop_addr_q;
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q, count_d;
  logic [31:0]     fifo_instr [DEPTH];
  logic [31:0]     fifo_pc    [DEPTH];
  logic            push, pop, has_free;
  logic [31:0]     redirect_pc_al;
  logic            unused_redirect_lsb;

  assign redirect_pc_al      = {redirect_pc[31:2], 2'b00};
  assign unused_redirect_lsb = ^redirect_pc[1:0];

  assign instr_valid = (count_q != '0);
  assign instr       = instr_valid ? fifo_instr[rd_ptr_q] : 32'h0000_0013;
  assign instr_pc    = instr_valid ? fifo_pc[rd_ptr_q] : 32'h0000_0000;
  assign fifo_count  = count_q;
  assign imem_req    = (state_q != S_IDLE);
  // A dropped request keeps presenting its original address while fetch_pc already holds the target.
  assign imem_addr   = (state_q == S_DROP) ? drop_addr_q : fetch_pc_q;

  always_comb begin
    push       = (state_q == S_WAIT) && imem_ack && !redirect;
    pop        = instr_valid && instr_ready && !redirect;
    count_d    = count_q + {{(CW-1){1'b0}}, push} - {{(CW-1){1'b0}}, pop};
    if (redirect) count_d = '0;
    has_free   = (count_d < CW'(DEPTH));
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    case (state_q)
      S_IDLE: begin
        if (redirect)      fetch_pc_d = redirect_pc_al;
        else if (has_free) state_d    = S_WAIT;
      end
      S_WAIT: begin
        if (redirect) begin
          fetch_pc_d = redirect_pc_al;
          state_d    = imem_ack ? S_IDLE : S_DROP;
        end else if (imem_ack) begin
          fetch_pc_d = fetch_pc_q + 32'd4;
          state_d    = has_free ? S_WAIT : S_IDLE;
        end
      end
      S_DROP: begin
        if (redirect) fetch_pc_d = redirect_pc_al;
        // The abandoned request still has to complete before a new one may start.
        if (imem_ack) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q     <= S_IDLE;
      fetch_pc_q  <= RESET_PC;
      drop_addr_q <= RESET_PC;
      count_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      count_q    <= count_d;
      if (state_q == S_WAIT && redirect && !imem_ack) drop_addr_q <= fetch_pc_q;
      if (redirect) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_instr[wr_ptr_q] <= imem_rdata;
      fifo_pc[wr_ptr_q]    <= fetch_pc_q;
    end
  end

endmodule
